// File: rtl/sniffer_pkg.sv
// Shared definitions for the sniffer datapath: ASCII constants,
// character classes and the number tokenizer state encoding.
package sniffer_pkg;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_MINUS = 8'h2D;

  typedef enum logic [1:0] {
    CC_DIGIT,
    CC_DELIM,
    CC_MINUS,
    CC_OTHER
  } char_class_t;

  typedef enum logic [1:0] {
    IDLE,
    SIGN,
    ACCUM,
    EMIT
  } tok_state_t;

endpackage

// File: rtl/char_classifier.sv
// Combinational ASCII classifier: digit / delimiter / minus / other,
// plus the binary value of a decimal digit (only meaningful for CC_DIGIT).
module char_classifier
  import sniffer_pkg::*;
#(
  parameter bit NEG_EN = 1'b1
) (
  input  logic [7:0]  in_char,
  output char_class_t char_class,
  output logic [3:0]  digit
);

  // Map one character to its class; '-' is a sign only when NEG_EN is set.
  always_comb begin
    digit      = in_char[3:0];
    char_class = CC_OTHER;
    if (in_char >= CH_0 && in_char <= CH_9) begin
      char_class = CC_DIGIT;
    end else if (in_char == CH_SP || in_char == CH_TAB || in_char == CH_LF ||
                 in_char == CH_CR || in_char == CH_COMMA) begin
      char_class = CC_DELIM;
    end else if (in_char == CH_MINUS) begin
      char_class = NEG_EN ? CC_MINUS : CC_DELIM;
    end
  end

endmodule

// File: rtl/number_tokenizer.sv
// Byte-stream number tokenizer: accumulates runs of decimal digits
// (optionally '-' prefixed) into a saturating magnitude and emits one
// token per terminated number.
//
// Handshakes: a character moves when in_valid & in_ready at a clk edge; a
// token moves when out_valid & out_ready at a clk edge. in_ready depends on
// the state only (low only while a token waits in EMIT), so out_ready never
// reaches in_ready combinationally, and output fields hold steady while
// out_valid & !out_ready.
module number_tokenizer
  import sniffer_pkg::*;
#(
  parameter int VALUE_W = 32,
  parameter int DIG_W   = 4,
  parameter int ERR_W   = 8,
  parameter bit NEG_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_char,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [VALUE_W-1:0] out_value,
  output logic               out_negative,
  output logic               out_overflow,
  output logic [DIG_W-1:0]   out_digits,
  output logic [ERR_W-1:0]   err_count,
  output tok_state_t         dbg_state
);

  tok_state_t          state, state_next;
  char_class_t         cls;
  logic [3:0]          digit;
  logic                accept;
  logic [VALUE_W-1:0]  acc;
  logic [DIG_W-1:0]    digits;
  logic                neg, ovf, pend_sign;
  logic [VALUE_W+3:0]  acc_ext, acc_mul;
  logic                acc_sat;
  logic                start_tok, start_neg, do_accum, do_emit;
  logic                err_inc, set_pend, clr_pend;

  char_classifier #(.NEG_EN(NEG_EN)) u_cls (
    .in_char    (in_char),
    .char_class (cls),
    .digit      (digit)
  );

  assign accept    = in_valid & in_ready;
  assign in_ready  = (state != EMIT);
  assign out_valid = (state == EMIT);
  assign dbg_state = state;

  // acc*10 + d with 4 guard bits; any guard bit or an earlier overflow saturates.
  assign acc_ext = {4'b0000, acc};
  assign acc_mul = (acc_ext << 3) + (acc_ext << 1) + {{VALUE_W{1'b0}}, digit};
  assign acc_sat = (|acc_mul[VALUE_W+3:VALUE_W]) | ovf;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and datapath control strobes.
  always_comb begin
    state_next = state;
    start_tok  = 1'b0;
    start_neg  = 1'b0;
    do_accum   = 1'b0;
    do_emit    = 1'b0;
    err_inc    = 1'b0;
    set_pend   = 1'b0;
    clr_pend   = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (cls == CC_DIGIT) begin
          start_tok  = 1'b1;
          state_next = ACCUM;
        end else if (cls == CC_MINUS) begin
          state_next = SIGN;
        end
      end
      SIGN: if (accept) begin
        case (cls)
          CC_DIGIT: begin
            start_tok  = 1'b1;
            start_neg  = 1'b1;
            state_next = ACCUM;
          end
          CC_DELIM: state_next = IDLE;
          CC_OTHER: begin
            err_inc    = 1'b1;
            state_next = IDLE;
          end
          default: state_next = SIGN;
        endcase
      end
      ACCUM: if (accept) begin
        case (cls)
          CC_DIGIT: do_accum = 1'b1;
          CC_DELIM: begin
            do_emit    = 1'b1;
            state_next = EMIT;
          end
          CC_MINUS: begin
            do_emit    = 1'b1;
            set_pend   = 1'b1;
            state_next = EMIT;
          end
          default: begin
            err_inc    = 1'b1;
            state_next = IDLE;
          end
        endcase
      end
      default: if (out_ready) begin
        clr_pend   = 1'b1;
        state_next = pend_sign ? SIGN : IDLE;
      end
    endcase
  end

  // Accumulator, output registers, pending sign and error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      digits       <= '0;
      neg          <= 1'b0;
      ovf          <= 1'b0;
      pend_sign    <= 1'b0;
      out_value    <= '0;
      out_negative <= 1'b0;
      out_overflow <= 1'b0;
      out_digits   <= '0;
      err_count    <= '0;
    end else begin
      if (start_tok) begin
        acc    <= {{(VALUE_W-4){1'b0}}, digit};
        digits <= DIG_W'(1);
        neg    <= start_neg;
        ovf    <= 1'b0;
      end
      if (do_accum) begin
        if (acc_sat) begin
          acc <= '1;
          ovf <= 1'b1;
        end else begin
          acc <= acc_mul[VALUE_W-1:0];
        end
        if (digits != '1) digits <= digits + DIG_W'(1);
      end
      if (do_emit) begin
        out_value    <= acc;
        out_negative <= neg;
        out_overflow <= ovf;
        out_digits   <= digits;
      end
      if (set_pend)      pend_sign <= 1'b1;
      else if (clr_pend) pend_sign <= 1'b0;
      if (err_inc && err_count != '1) err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_number_tokenizer.sv
// Bench for number_tokenizer: a 32-bit instance (a) and an 8-bit value /
// 2-bit error counter instance (b) share one input stream.
module tb_number_tokenizer;
  import sniffer_pkg::*;

  typedef struct packed {
    logic [31:0] value;
    logic        neg;
    logic        ovf;
    logic [3:0]  digits;
  } tok_t;

  typedef struct {
    string s;
    int    ntok;
    tok_t  t0;
    tok_t  t1;
    int    err;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic        out_ready = 1'b1;
  logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b;
  logic [31:0] out_value_a;
  logic [7:0]  out_value_b;
  logic        out_negative_a, out_negative_b, out_overflow_a, out_overflow_b;
  logic [3:0]  out_digits_a, out_digits_b;
  logic [7:0]  err_count_a;
  logic [1:0]  err_count_b;
  tok_state_t  dbg_state_a, dbg_state_b;

  number_tokenizer #(.VALUE_W(32), .DIG_W(4), .ERR_W(8), .NEG_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_char(in_char), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_value(out_value_a), .out_negative(out_negative_a),
    .out_overflow(out_overflow_a), .out_digits(out_digits_a),
    .err_count(err_count_a), .dbg_state(dbg_state_a)
  );

  number_tokenizer #(.VALUE_W(8), .DIG_W(4), .ERR_W(2), .NEG_EN(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_char(in_char), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_value(out_value_b), .out_negative(out_negative_b),
    .out_overflow(out_overflow_b), .out_digits(out_digits_b),
    .err_count(err_count_b), .dbg_state(dbg_state_b)
  );

  // ---------------- scoreboard ----------------
  int   checks = 0;
  int   errors = 0;
  tok_t exp_qa[$];
  tok_t exp_qb[$];
  bit   use_model_a = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic tok_t mk(input logic [31:0] v, input bit n, input bit o, input int d);
    tok_t t;
    t.value  = v;
    t.neg    = n;
    t.ovf    = o;
    t.digits = 4'(d);
    return t;
  endfunction

  // Token handshakes at the next edge; sample mid-cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid_a && out_ready) begin
      if (exp_qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL tok_a: unexpected token value %0h", out_value_a);
      end else begin
        check("tok_a", {out_value_a, out_negative_a, out_overflow_a, out_digits_a}, exp_qa.pop_front());
      end
    end
    if (rst_n && out_valid_b && out_ready) begin
      if (exp_qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL tok_b: unexpected token value %0h", out_value_b);
      end else begin
        check("tok_b", {24'h0, out_value_b, out_negative_b, out_overflow_b, out_digits_b}, exp_qb.pop_front());
      end
    end
  end

  // ---------------- reference model ----------------
  // Tracks where the stream is within a number and the exact decimal value,
  // capping it once it exceeds what the output width can hold.
  int     m_mode[2];   // 0 between numbers, 1 after '-', 2 inside digits
  longint m_val[2];
  bit     m_ovf[2];
  bit     m_neg[2];
  int     m_dig[2];
  int     m_err[2];
  longint m_max[2] = '{64'hFFFF_FFFF, 64'd255};
  int     m_emax[2] = '{255, 3};

  function automatic int char_kind(input byte c);
    if (c >= "0" && c <= "9") return 0;
    if (c == " " || c == 8'h09 || c == 8'h0A || c == 8'h0D || c == ",") return 1;
    if (c == "-") return 2;
    return 3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_val[i] = 0; m_ovf[i] = 0; m_neg[i] = 0; m_dig[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic model_char(input int i, input byte c);
    int   k;
    tok_t t;
    k = char_kind(c);
    if (k == 0 && m_mode[i] != 2) begin
      m_val[i] = longint'(c - 8'h30); m_dig[i] = 1; m_ovf[i] = 0;
      m_neg[i] = (m_mode[i] == 1); m_mode[i] = 2;
    end else if (k == 0) begin
      if (!m_ovf[i]) begin
        m_val[i] = m_val[i] * 10 + longint'(c - 8'h30);
        if (m_val[i] > m_max[i]) m_ovf[i] = 1;
      end
      m_dig[i]++;
    end else if (k == 3) begin
      if (m_mode[i] != 0 && m_err[i] < m_emax[i]) m_err[i]++;
      m_mode[i] = 0;
    end else if (m_mode[i] == 2) begin
      t = mk(m_ovf[i] ? 32'(m_max[i]) : 32'(m_val[i]), m_neg[i], m_ovf[i],
             (m_dig[i] > 15) ? 15 : m_dig[i]);
      if (i == 1) exp_qb.push_back(t);
      else if (use_model_a) exp_qa.push_back(t);
      m_mode[i] = (k == 2) ? 1 : 0;
    end else if (k == 2) begin
      m_mode[i] = 1;
    end else begin
      m_mode[i] = 0;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_char(input byte c, input bit rand_ready);
    int n;
    bit took;
    n = 0;
    took = 0;
    in_valid = 1'b1;
    in_char  = c;
    do begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      took = in_ready_a;
      @(posedge clk); #1;
      n++;
    end while (!took && n < 64);
    in_valid = 1'b0;
    if (!took) begin
      checks++; errors++;
      $display("FAIL accept_timeout: char %0h not accepted after %0d cycles", c, n);
    end else begin
      model_char(0, c);
      model_char(1, c);
    end
  endtask

  task automatic send_str(input string s, input bit rand_ready);
    for (int k = 0; k < s.len(); k++) send_char(s[k], rand_ready);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_qa.size() != 0 || exp_qb.size() != 0) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) begin @(posedge clk); #1; end
    check({name, "_pending_a"}, exp_qa.size(), 0);
    check({name, "_pending_b"}, exp_qb.size(), 0);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_valid"},  out_valid_a, 0);
    check({name, "_value"},  out_value_a, 0);
    check({name, "_neg"},    out_negative_a, 0);
    check({name, "_ovf"},    out_overflow_a, 0);
    check({name, "_digits"}, out_digits_a, 0);
    check({name, "_err"},    err_count_a, 0);
    check({name, "_ready"},  in_ready_a, 1);
    check({name, "_valid_b"}, out_valid_b, 0);
    check({name, "_err_b"},  err_count_b, 0);
  endtask

  vec_t tbl[13];

  task automatic set_vec(input int i, input string s, input int ntok, input tok_t t0, input tok_t t1, input int err);
    tbl[i].s = s; tbl[i].ntok = ntok; tbl[i].t0 = t0; tbl[i].t1 = t1; tbl[i].err = err;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    byte c;
    int  r;
    string alpha;

    set_vec(0,  "-305\n",                1, mk(305, 1, 0, 3), mk(0, 0, 0, 0), 0);
    set_vec(1,  "7-3 ",                  2, mk(7, 0, 0, 1),   mk(3, 1, 0, 1), 0);
    set_vec(2,  "300 ",                  1, mk(300, 0, 0, 3), mk(0, 0, 0, 0), 0);
    set_vec(3,  "5 ",                    1, mk(5, 0, 0, 1),   mk(0, 0, 0, 0), 0);
    set_vec(4,  "1a2 x ",                1, mk(2, 0, 0, 1),   mk(0, 0, 0, 0), 1);
    set_vec(5,  "007,",                  1, mk(7, 0, 0, 3),   mk(0, 0, 0, 0), 1);
    set_vec(6,  "99999999999 ",          1, mk(32'hFFFF_FFFF, 0, 1, 11), mk(0, 0, 0, 0), 1);
    set_vec(7,  "0000000000000000001 ",  1, mk(1, 0, 0, 15),  mk(0, 0, 0, 0), 1);
    set_vec(8,  "--8\t",                 1, mk(8, 1, 0, 1),   mk(0, 0, 0, 0), 1);
    set_vec(9,  "-x ",                   0, mk(0, 0, 0, 0),   mk(0, 0, 0, 0), 2);
    set_vec(10, "- 4\015",               1, mk(4, 0, 0, 1),   mk(0, 0, 0, 0), 2);
    set_vec(11, "4294967295 ",           1, mk(32'hFFFF_FFFF, 0, 0, 10), mk(0, 0, 0, 0), 2);
    set_vec(12, "4294967296 ",           1, mk(32'hFFFF_FFFF, 0, 1, 10), mk(0, 0, 0, 0), 2);

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // "12 ": token valid right after the terminator edge, not before.
    exp_qa.push_back(mk(12, 0, 0, 2));
    send_char("1", 0);
    send_char("2", 0);
    check("lat_before", out_valid_a, 0);
    send_char(" ", 0);
    check("lat_after", out_valid_a, 1);
    check("lat_in_ready", in_ready_a, 0);
    drain("lat");

    // Directed vectors.
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].ntok > 0) exp_qa.push_back(tbl[i].t0);
      if (tbl[i].ntok > 1) exp_qa.push_back(tbl[i].t1);
      send_str(tbl[i].s, 0);
      drain("vec");
      check("vec_err_a", err_count_a, tbl[i].err);
      check("vec_err_b", err_count_b, m_err[1]);
    end

    // Backpressure: "42,9 " with out_ready low for 5 cycles.
    exp_qa.push_back(mk(42, 0, 0, 2));
    exp_qa.push_back(mk(9, 0, 0, 1));
    out_ready = 1'b0;
    send_str("42,", 0);
    in_valid = 1'b1;
    in_char  = "9";
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", out_valid_a, 1);
      check("bp_in_ready", in_ready_a, 0);
      check("bp_value", out_value_a, 42);
      check("bp_digits", out_digits_a, 2);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    check("bp_in_ready_last", in_ready_a, 0);
    @(posedge clk); #1;
    check("bp_after_hs_valid", out_valid_a, 0);
    check("bp_after_hs_ready", in_ready_a, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_char(0, "9");
    model_char(1, "9");
    check("bp_nine_taken", dbg_state_a, ACCUM);
    send_char(" ", 0);
    drain("bp");

    // Five discarded tokens: a counts to 7, b saturates at 3.
    for (int k = 0; k < 5; k++) send_str("1a", 0);
    send_char(" ", 0);
    drain("bad");
    check("bad_err_a", err_count_a, 7);
    check("bad_err_b", err_count_b, 3);

    // Reset in the middle of "123".
    send_str("123", 0);
    #2;
    rst_n = 1'b0;
    exp_qa.delete();
    exp_qb.delete();
    model_reset();
    #1;
    check_zero_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset while a token waits in EMIT.
    out_ready = 1'b0;
    send_str("5 ", 0);
    check("rst_emit_valid_before", out_valid_a, 1);
    #3;
    rst_n = 1'b0;
    exp_qb.delete();
    model_reset();
    #1;
    check_zero_outputs("rst_emit");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    exp_qa.push_back(mk(8, 0, 0, 1));
    send_str("8 ", 0);
    drain("rst_after");

    // Random stream checked against the model, with random out_ready.
    use_model_a = 1'b1;
    alpha = "0123456789 ,-x";
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 17);
      if (r < 14) c = alpha[r];
      else if (r == 14) c = 8'h0A;
      else if (r == 15) c = 8'h09;
      else c = alpha[$urandom_range(0, 9)];
      send_char(c, 1);
    end
    out_ready = 1'b1;
    send_char(" ", 0);
    drain("rand");
    check("rand_err_a", err_count_a, m_err[0]);
    check("rand_err_b", err_count_b, m_err[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/number_tokenizer.md
# number_tokenizer

Parametrised byte-stream number tokenizer for the sniffer datapath. It classifies each incoming character as digit, delimiter, minus or other, and accumulates runs of decimal digits into a binary magnitude with a sign flag. It emits one token per terminated number on a valid/ready output and counts malformed tokens. It sits between the UART receive byte stream and the downstream value consumers, replacing single-cycle character flagging with full token extraction.

## Interface
- `VALUE_W`, 32: width of the accumulated magnitude.
- `DIG_W`, 4: width of the digit-count output; the count saturates at 2^DIG_W-1.
- `ERR_W`, 8: width of the saturating error counter.
- `NEG_EN`, 1: 1 treats '-' as a sign prefix; 0 treats '-' as a delimiter.
- Reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  `in_char` valid.
- `in_ready`  out  1  tokenizer accepts `in_char` this cycle.
- `in_char`  in  8  ASCII character.
- `out_valid`  out  1  token available.
- `out_ready`  in  1  consumer takes the token.
- `out_value`  out  VALUE_W  token magnitude.
- `out_negative`  out  1  token had a '-' prefix.
- `out_overflow`  out  1  magnitude saturated.
- `out_digits`  out  DIG_W  digits consumed, saturating.
- `err_count`  out  ERR_W  tokens discarded, saturating.

## Operation
- Character classes:
  - DIGIT: 0x30–0x39.
  - DELIM: 0x20, 0x09, 0x0A, 0x0D, ','. Also '-' when NEG_EN=0.
  - MINUS: '-' when NEG_EN=1.
  - OTHER: everything else.
- A character is consumed only when `in_valid & in_ready`.
- FSM states: IDLE, SIGN, ACCUM, EMIT.
- IDLE:
  - DIGIT → ACCUM; acc=d, digits=1, neg=0.
  - MINUS → SIGN.
  - DELIM or OTHER → stay IDLE; no error is counted.
- SIGN:
  - DIGIT → ACCUM; acc=d, neg=1.
  - MINUS → stay SIGN.
  - DELIM → IDLE.
  - OTHER → IDLE and err_count+1.
- ACCUM:
  - DIGIT → acc = acc*10 + d, digits+1.
  - DELIM → EMIT.
  - MINUS → EMIT and set `pend_sign`.
  - OTHER → discard the token, err_count+1, go to IDLE.
- EMIT:
  - `out_valid`=1 and `in_ready`=0.
  - On `out_ready`, go to SIGN if `pend_sign` is set, else IDLE. Clear `pend_sign`.
- Arithmetic: acc*10 is computed as (acc<<3)+(acc<<1)+d in VALUE_W+4 bits.
  - If any bit above VALUE_W-1 is set, or `out_overflow` is already set, acc = all-ones and `out_overflow` is set.
  - `out_overflow` is sticky until the token is emitted.
- Leading zeros are accumulated normally. "007" gives value 7, digits 3.
- Output fields are registers loaded on entry to EMIT. They are stable while `out_valid & !out_ready`.
- err_count saturates at 2^ERR_W-1 and never wraps.
- Reset values:
  - `out_valid`=0, `out_value`=0, `out_negative`=0, `out_overflow`=0, `out_digits`=0, `err_count`=0.
  - FSM in IDLE, `pend_sign`=0.
  - `in_ready`=1.
- Reset mid-token: the partial token is dropped and no output is produced.
- Reset during EMIT: `out_valid` falls asynchronously.

## Timing
- `in_ready` is a function of the state only: it is 0 only in EMIT. There is no combinational path from `out_ready` to `in_ready`.
- Latency: a terminator accepted at edge N gives `out_valid`=1 after edge N, visible in cycle N+1.
- The token handshakes at the first edge where `out_valid & out_ready`. `in_ready` returns to 1 in the following cycle.
- Throughput: 1 char/cycle, plus exactly one non-accepting cycle per emitted token when `out_ready` is held at 1.
- Backpressure: EMIT holds for as many cycles as `out_ready` is low. No input is lost, because `in_ready` is 0 during EMIT.
- Simultaneous events:
  - An OTHER char with err_count at maximum: the token is still discarded and the count stays at maximum.
  - An overflowing digit: saturation is applied in the same edge as the accumulate.

## Structure
- Shared package `sniffer_pkg` holds:
  - Character constants (CH_0, CH_9, CH_SP, CH_TAB, CH_LF, CH_CR, CH_COMMA, CH_MINUS).
  - Enum `char_class_t` {CC_DIGIT, CC_DELIM, CC_MINUS, CC_OTHER}.
  - Enum `tok_state_t` {IDLE, SIGN, ACCUM, EMIT}.
- Sub-module `char_classifier`: purely combinational. Inputs are `in_char` and `NEG_EN`. Outputs are `char_class_t` and the 4-bit digit value. It is reused by later sniffer blocks.
- The top level holds the FSM, accumulator, counters and output registers.

## Test plan
- Stream "12 " with `out_ready`=1 → one token: value 12, negative 0, digits 2, overflow 0. Token is valid in the cycle after ' ' is accepted.
- Stream "-305\n" → value 305, negative 1, digits 3. Stream "7-3 " → token 7 (neg 0), then token 3 (neg 1).
- With VALUE_W=8, stream "300 " → value 255, overflow 1, digits 3. The next token "5 " has overflow 0.
- Stream "42,9 " with `out_ready` low for 5 cycles on the first token:
  - The 42 token is held stable for those 5 cycles.
  - `in_ready`=0 throughout the hold.
  - '9' is accepted only after the handshake.
- Stream "1a2 x " → no token from "1a"; token 2 is emitted; err_count=1, since 'x' in IDLE is not an error. With ERR_W=2 and 5 bad tokens, err_count=3.
- Assert `rst_n` low mid-"123" and again during EMIT with `out_ready`=0:
  - `out_valid` drops immediately and all outputs read zero.
  - After release, "8 " produces a single token 8.
